if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage. Sits directly upstream of the memory controller's IF port.
//  - Holds the PC and issues one word fetch at a time (if_re/if_addr).
//  - Waits for the controller's done pulse, then presents {pc, inst} to ID through a valid/ready register.
//  - Handles branch redirects from EX, including killing a fetch that is already in flight.
// PARAMETERS
//  ADDR_W    32            PC / fetch address width
//  INST_W    32            instruction width
//  RESET_PC  32'h00000000  PC loaded on reset
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  rst          in   1       synchronous, active-low reset (rst==0 at posedge resets)
//  rdy          in   1       global enable; 0 = freeze all state, outputs held
//  if_re_o      out  1       fetch request to memory controller
//  if_addr_o    out  ADDR_W  fetch address (= pc, low 2 bits 0)
//  mem_busy_i   in   1       controller busy (registered, 1 while serving a request)
//  mem_req_i    in   1       MEM stage has read/write request pending (wins arbitration)
//  mem_done_i   in   1       controller done pulse
//  mem_data_i   in   INST_W  controller read data, valid with mem_done_i
//  jump_i       in   1       redirect from EX, single-cycle pulse
//  jump_addr_i  in   ADDR_W  redirect target
//  id_ready_i   in   1       ID can accept this cycle
//  inst_valid_o out  1       inst_o/pc_o valid
//  inst_o       out  INST_W  fetched instruction
//  pc_o         out  ADDR_W  address of inst_o
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=REQ, kill=0, inst_valid_o=0, inst_o=0, pc_o=0.
//  Reset overrides rdy. rdy=0 freezes state, pc, kill and the output regs.
//  if_re_o = (state==REQ) and is driven from state only. if_addr_o = pc.
//  Accept: at a posedge where state==REQ && !mem_busy_i && !mem_req_i. The controller samples the same edge.
//  States (one-hot):
//   REQ  - on accept -> WAIT; otherwise stay.
//   WAIT - first mem_done_i cycle after entry carries this fetch's data.
//          kill==0: inst_o<=mem_data_i, pc_o<=pc, inst_valid_o<=1, pc<=pc+4, -> HOLD.
//          kill==1: drop the data, kill<=0, -> REQ.
//   HOLD - on inst_valid_o && id_ready_i: inst_valid_o<=0, -> REQ.
//  Latency: cache hit gives valid 2 cycles after entering REQ (accept edge, then done edge).
//  Arithmetic: pc+4 wraps modulo 2^ADDR_W. jump_addr_i[1:0] are forced to 0.
//  Redirect (jump_i=1) has priority over everything except reset. pc<=jump_addr_i and inst_valid_o<=0 in all cases.
//   REQ without accept -> stay REQ (new addr next cycle).
//   REQ with accept (old addr) -> WAIT, kill<=1.
//   WAIT, no done -> stay WAIT, kill<=1.
//   WAIT with done -> drop data, kill<=0, -> REQ.
//   HOLD -> REQ. This holds even if id_ready_i=1 that cycle; ID is flushed by the same jump.
//  Only one fetch is outstanding at any time. No request is issued while the output reg is occupied.
//  mem_done_i outside WAIT is ignored (it belongs to MEM).
// STRUCTURE
//  Shared defines file: state encodings IF_REQ/IF_WAIT/IF_HOLD, `MemAddrBus, `InstWidth, RESET_PC default.
//  Single flat module with one always block (state, pc, kill, output regs); no sub-module.
// TESTING
//  1 Reset, RESET_PC=0, controller hit model (done 1 cycle after accept).
//    -> if_addr 0,4,8; inst_valid_o on cycles 2,5,8 with id_ready_i=1.
//  2 mem_req_i=1 for 3 cycles while in REQ.
//    -> no accept; if_re_o stays 1; accept on first cycle mem_req_i=0 && mem_busy_i=0.
//  3 Miss model (busy 4 cycles, data 32'h00500093).
//    -> inst_o=32'h00500093, pc_o=0; next if_addr_o=4 only after id_ready_i.
//  4 jump_i with jump_addr_i=32'h1002 while in WAIT; done arrives 2 cycles later.
//    -> data dropped, inst_valid_o stays 0; next fetch at 32'h1000.
//  5 id_ready_i=0 for 5 cycles in HOLD.
//    -> inst_o/pc_o stable, if_re_o=0; then jump_i and id_ready_i together -> inst_valid_o=0, fetch jump target.
//  6 rdy=0 mid-WAIT, then rst=0 with rdy=0, and pc=32'hFFFFFFFC increment.
//    -> state frozen under rdy=0; reset still applies; pc wraps to 0.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_fetch_pkg;

  // Default bus widths and the PC that is loaded on reset.
  localparam int          IF_ADDR_W   = 32;
  localparam int          IF_INST_W   = 32;
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

  // One-hot fetch states: REQ issues a fetch, WAIT waits for the controller's
  // done pulse, HOLD keeps a fetched word until ID takes it.
  typedef enum logic [2:0] {
    IF_REQ  = 3'b001,
    IF_WAIT = 3'b010,
    IF_HOLD = 3'b100
  } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: holds the PC, issues one word fetch at a time to the
// memory controller and hands {pc, inst} to ID through a valid/ready register.
// EX redirects are applied immediately; a fetch already in flight when a
// redirect arrives is remembered in kill and its data is dropped on return.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = IF_ADDR_W,
  parameter int                INST_W   = IF_INST_W,
  parameter logic [ADDR_W-1:0] RESET_PC = IF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              if_re_o,
  output logic [ADDR_W-1:0] if_addr_o,
  input  logic              mem_busy_i,
  input  logic              mem_req_i,
  input  logic              mem_done_i,
  input  logic [INST_W-1:0] mem_data_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              id_ready_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  // Word alignment: the two low address bits are always zero.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

  if_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                kill_q, kill_d;
  logic                valid_q, valid_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;

  logic                accept;
  logic [ADDR_W-1:0]   jump_tgt;
  logic [ADDR_W-1:0]   pc_inc;

  // The controller takes our request on the same edge when it is idle and
  // MEM is not competing for it.
  assign accept   = (state_q == IF_REQ) && !mem_busy_i && !mem_req_i;
  assign jump_tgt = jump_addr_i & ALIGN_MASK;
  assign pc_inc   = pc_q + WORD_STEP;

  // Next-state logic: redirects first, otherwise the normal fetch sequence.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    kill_d   = kill_q;
    valid_d  = valid_q;
    inst_d   = inst_q;
    pc_out_d = pc_out_q;

    if (jump_i) begin
      // A redirect always retargets the PC and flushes the output register.
      pc_d    = jump_tgt;
      valid_d = 1'b0;
      case (state_q)
        IF_REQ: begin
          // If the old address is being accepted right now, its data must be
          // discarded when it comes back.
          if (accept) begin
            state_d = IF_WAIT;
            kill_d  = 1'b1;
          end
        end
        IF_WAIT: begin
          if (mem_done_i) begin
            state_d = IF_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        IF_HOLD: begin
          // ID is flushed by the same redirect, so a same-cycle handshake is moot.
          state_d = IF_REQ;
        end
        default: begin
          state_d = IF_REQ;
          kill_d  = 1'b0;
        end
      endcase
    end else begin
      case (state_q)
        IF_REQ: begin
          if (accept) begin
            state_d = IF_WAIT;
          end
        end
        IF_WAIT: begin
          // The first done after entering WAIT belongs to this fetch.
          if (mem_done_i) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = IF_REQ;
            end else begin
              inst_d   = mem_data_i;
              pc_out_d = pc_q;
              valid_d  = 1'b1;
              pc_d     = pc_inc;
              state_d  = IF_HOLD;
            end
          end
        end
        IF_HOLD: begin
          if (valid_q && id_ready_i) begin
            valid_d = 1'b0;
            state_d = IF_REQ;
          end
        end
        default: begin
          state_d = IF_REQ;
          kill_d  = 1'b0;
        end
      endcase
    end
  end

  // State register: reset wins over rdy; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IF_REQ;
      pc_q     <= RESET_PC & ALIGN_MASK;
      kill_q   <= 1'b0;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      pc_out_q <= '0;
    end else if (rdy) begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      kill_q   <= kill_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      pc_out_q <= pc_out_d;
    end
  end

  assign if_re_o      = (state_q == IF_REQ);
  assign if_addr_o    = pc_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign pc_o         = pc_out_q;

endmodule
